// File: rtl/ica_pkg.sv
// ica_pkg: shared constants, types and arithmetic helpers for the FastICA front end.
package ica_pkg;
   localparam int DW        = 26;
   localparam int N_SAMPLES = 128;
   localparam int LOG2_N    = 7;
   localparam int PW        = 2 * DW;
   localparam int SW        = DW + LOG2_N;

   typedef logic signed [DW-1:0] sample_t;
   typedef logic signed [PW-1:0] prod_t;
   typedef logic signed [SW-1:0] sum_t;
   typedef enum logic [1:0] {FILL, MEAN, STREAM, FLUSH} state_t;

   // Subtract at DW+1 bits, then clip back into the DW-bit signed range.
   function automatic sample_t center(input sample_t x, input sample_t m);
      logic signed [DW:0] d;
      d = (DW+1)'(x) - (DW+1)'(m);
      return (d[DW] == d[DW-1]) ? sample_t'(d) : {d[DW], {(DW-1){~d[DW]}}};
   endfunction

   function automatic prod_t mul(input sample_t a, input sample_t b);
      return prod_t'(a) * prod_t'(b);
   endfunction
endpackage

// File: rtl/ica_frame_buffer.sv
// ica_frame_buffer: one-frame simple dual-port RAM with registered read (block-RAM friendly).
module ica_frame_buffer
   import ica_pkg::*;
(
   input  logic                clk,
   input  logic                we,
   input  logic [LOG2_N-1:0]   waddr,
   input  logic [4*DW-1:0]     wdata,
   input  logic [LOG2_N-1:0]   raddr,
   output logic [4*DW-1:0]     rdata
);
   logic [4*DW-1:0] mem_q [N_SAMPLES];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
      rdata <= mem_q[raddr];
   end
endmodule

// File: rtl/cov_sample_centerer.sv
// cov_sample_centerer: buffers a 128-sample 4-channel frame, removes the mean and
// streams the 10 unique pairwise products plus one finalize cycle to the covariance stage.
module cov_sample_centerer
   import ica_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] x1,
   input  logic signed [DW-1:0] x2,
   input  logic signed [DW-1:0] x3,
   input  logic signed [DW-1:0] x4,
   output logic                 en_out,
   output logic signed [PW-1:0] X1X1,
   output logic signed [PW-1:0] X1X2,
   output logic signed [PW-1:0] X1X3,
   output logic signed [PW-1:0] X1X4,
   output logic signed [PW-1:0] X2X2,
   output logic signed [PW-1:0] X2X3,
   output logic signed [PW-1:0] X2X4,
   output logic signed [PW-1:0] X3X3,
   output logic signed [PW-1:0] X3X4,
   output logic signed [PW-1:0] X4X4,
   output logic                 busy,
   output logic                 frame_done
);
   state_t            state_q;
   logic [LOG2_N-1:0] wr_ptr_q, rd_ptr_q;
   sum_t              sum_q  [4];
   sample_t           mean_q [4];
   sample_t           c_q    [4];
   sample_t           xin    [4];
   prod_t             p_q    [10];
   logic [4*DW-1:0]   rdata;
   logic              v1_q, v2_q, v3_q, fin_q, done_q, hs;

   assign xin        = '{x1, x2, x3, x4};
   assign in_ready   = (state_q == FILL);
   assign busy       = (state_q != FILL);
   assign hs         = in_valid & in_ready;
   assign en_out     = v3_q | fin_q;
   assign frame_done = done_q;
   assign {X1X1, X1X2, X1X3, X1X4, X2X2, X2X3, X2X4, X3X3, X3X4, X4X4} =
          {p_q[0], p_q[1], p_q[2], p_q[3], p_q[4], p_q[5], p_q[6], p_q[7], p_q[8], p_q[9]};

   ica_frame_buffer u_buf (
      .clk   (clk),
      .we    (hs),
      .waddr (wr_ptr_q),
      .wdata ({x4, x3, x2, x1}),
      .raddr (rd_ptr_q),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FILL;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         v3_q     <= 1'b0;
         fin_q    <= 1'b0;
         done_q   <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            sum_q[k]  <= '0;
            mean_q[k] <= '0;
            c_q[k]    <= '0;
         end
         for (int k = 0; k < 10; k++) p_q[k] <= '0;
      end else begin
         v1_q   <= (state_q == STREAM);
         v2_q   <= v1_q;
         v3_q   <= v2_q;
         // Last product cycle seen: add the finalize cycle with zero products.
         fin_q  <= (state_q == FLUSH) && v3_q && !v2_q;
         done_q <= fin_q;
         for (int k = 0; k < 4; k++) c_q[k] <= center(rdata[k*DW +: DW], mean_q[k]);
         p_q[0] <= v2_q ? mul(c_q[0], c_q[0]) : '0;
         p_q[1] <= v2_q ? mul(c_q[0], c_q[1]) : '0;
         p_q[2] <= v2_q ? mul(c_q[0], c_q[2]) : '0;
         p_q[3] <= v2_q ? mul(c_q[0], c_q[3]) : '0;
         p_q[4] <= v2_q ? mul(c_q[1], c_q[1]) : '0;
         p_q[5] <= v2_q ? mul(c_q[1], c_q[2]) : '0;
         p_q[6] <= v2_q ? mul(c_q[1], c_q[3]) : '0;
         p_q[7] <= v2_q ? mul(c_q[2], c_q[2]) : '0;
         p_q[8] <= v2_q ? mul(c_q[2], c_q[3]) : '0;
         p_q[9] <= v2_q ? mul(c_q[3], c_q[3]) : '0;
         case (state_q)
            FILL: if (hs) begin
               for (int k = 0; k < 4; k++) sum_q[k] <= sum_q[k] + sum_t'(xin[k]);
               wr_ptr_q <= wr_ptr_q + LOG2_N'(1);
               if (wr_ptr_q == LOG2_N'(N_SAMPLES-1)) state_q <= MEAN;
            end
            MEAN: begin
               for (int k = 0; k < 4; k++) begin
                  mean_q[k] <= sample_t'(sum_q[k] >>> LOG2_N);
                  sum_q[k]  <= '0;
               end
               wr_ptr_q <= '0;
               state_q  <= STREAM;
            end
            STREAM: begin
               rd_ptr_q <= rd_ptr_q + LOG2_N'(1);
               if (rd_ptr_q == LOG2_N'(N_SAMPLES-1)) state_q <= FLUSH;
            end
            FLUSH: if (fin_q) state_q <= FILL;
            default: state_q <= FILL;
         endcase
      end
   end
endmodule
